tlb_port_sched: RTL and testbench

- Schedules the shared TLB search port 1 between two requesters: data-side address translation in EXE, and the TLBP instruction, which probes with CP0 EntryHi.
- Resolves the EntryHi write-after-read hazard before a probe is issued.
- Blocks data translation from a TLBWI/TLBR commit until fetch restarts, so no stale mapping is used.
- Sits between the EXE stage, the WB-stage CP0/TLB logic and the TLB search port.

---
 rtl/tlb_port_sched_pkg.sv | 30 +++
 rtl/tlb_port_sched_sat_counter.sv | 33 +++
 rtl/tlb_port_sched.sv | 197 +++++++++++++++++++
 tb/tb_tlb_port_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_port_sched_pkg.sv
// tlb_port_sched_pkg: shared definitions for the TLB search-port scheduler.
//   - FSM state encodings
//   - CP0 EntryHi field positions and field-extraction helpers
package tlb_port_sched_pkg;

  typedef enum logic [2:0] {
    TPS_IDLE  = 3'd0,
    TPS_HAZ   = 3'd1,
    TPS_PROBE = 3'd2,
    TPS_RESP  = 3'd3,
    TPS_SYNC  = 3'd4
  } tps_state_e;

  localparam int EH_VPN2_MSB = 31;
  localparam int EH_VPN2_LSB = 13;
  localparam int EH_ODD_BIT  = 12;
  localparam int EH_ASID_MSB = 7;
  localparam int EH_ASID_LSB = 0;

  // VPN2 field of an EntryHi value
  function automatic logic [18:0] eh_vpn2(input logic [31:0] eh);
    return eh[EH_VPN2_MSB:EH_VPN2_LSB];
  endfunction

  // ASID field of an EntryHi value
  function automatic logic [7:0] eh_asid(input logic [31:0] eh);
    return eh[EH_ASID_MSB:EH_ASID_LSB];
  endfunction

endpackage

// File: rtl/tlb_port_sched_sat_counter.sv
// sat_counter: width-parameterised up-counter that sticks at all-ones.
//   clk   in  clock
//   reset in  synchronous active-high clear
//   en    in  count enable
//   cnt   out registered count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic [W-1:0] cnt_r;

  // Count register: advance on enable until all-ones, then hold
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
    end else if (en && (cnt_r != ONES)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/tlb_port_sched.sv
// tlb_port_sched: arbitrates TLB search port 1 between EXE data translation
// and the TLBP probe (which searches with CP0 EntryHi). Holds a probe off
// while an MTC0 EntryHi is still in flight, and blocks data translation
// after a TLBWI/TLBR commit until fetch restarts.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   dt_req/dt_vpn2/dt_odd       EXE data translation request and address
//   dt_gnt                      search port granted to data (combinational)
//   tp_req                      TLBP valid in EXE
//   tp_done/tp_found/tp_index   probe completion pulse and registered result
//   eh_wr_pending, cp0_entryhi  EntryHi write hazard flag and current value
//   s1_vpn2/s1_odd_page/s1_asid search port request
//   s1_found/s1_index           search port response (combinational)
//   tlbw_commit, flush          WB-stage TLB write commit and pipeline flush
//   fetch_restart               first fetch after a flush issued
//   sync_busy                   controller is waiting for fetch restart
//   deny_cnt                    saturating count of denied data cycles
module tlb_port_sched
  import tlb_port_sched_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM),
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dt_req,
  input  logic [18:0]     dt_vpn2,
  input  logic            dt_odd,
  output logic            dt_gnt,
  input  logic            tp_req,
  output logic            tp_done,
  output logic            tp_found,
  output logic [IDXW-1:0] tp_index,
  input  logic            eh_wr_pending,
  input  logic [31:0]     cp0_entryhi,
  output logic [18:0]     s1_vpn2,
  output logic            s1_odd_page,
  output logic [7:0]      s1_asid,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  input  logic            tlbw_commit,
  input  logic            flush,
  input  logic            fetch_restart,
  output logic            sync_busy,
  output logic [CNTW-1:0] deny_cnt
);

  tps_state_e      state_r;
  tps_state_e      state_nxt_s;
  logic            dt_gnt_s;
  logic            tp_done_s;
  logic            probe_cap_s;
  logic            sync_busy_s;
  logic [18:0]     s1_vpn2_s;
  logic            s1_odd_s;
  logic            tp_found_r;
  logic [IDXW-1:0] tp_index_r;
  logic            deny_en_s;
  logic            unused_eh_s;

  // EntryHi bits between ASID and the odd-page bit carry nothing for the search
  assign unused_eh_s = ^cp0_entryhi[11:8];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TPS_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A TLB write commit always wins so that no data lookup
  // can use the mapping being replaced; SYNC only leaves on fetch restart.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      TPS_IDLE: begin
        if (tlbw_commit) begin
          state_nxt_s = TPS_SYNC;
        end else if (flush) begin
          state_nxt_s = TPS_IDLE;
        end else if (tp_req) begin
          state_nxt_s = eh_wr_pending ? TPS_HAZ : TPS_PROBE;
        end else begin
          state_nxt_s = TPS_IDLE;
        end
      end
      TPS_HAZ: begin
        if (tlbw_commit) begin
          state_nxt_s = TPS_SYNC;
        end else if (flush || !tp_req) begin
          state_nxt_s = TPS_IDLE;
        end else if (!eh_wr_pending) begin
          state_nxt_s = TPS_PROBE;
        end else begin
          state_nxt_s = TPS_HAZ;
        end
      end
      TPS_PROBE: begin
        if (tlbw_commit) begin
          state_nxt_s = TPS_SYNC;
        end else if (flush) begin
          state_nxt_s = TPS_IDLE;
        end else begin
          state_nxt_s = TPS_RESP;
        end
      end
      TPS_RESP: begin
        if (tlbw_commit) begin
          state_nxt_s = TPS_SYNC;
        end else begin
          state_nxt_s = TPS_IDLE;
        end
      end
      TPS_SYNC: begin
        if (fetch_restart) begin
          state_nxt_s = TPS_IDLE;
        end else begin
          state_nxt_s = TPS_SYNC;
        end
      end
      default: begin
        state_nxt_s = TPS_IDLE;
      end
    endcase
  end

  // Output decode and search-port mux. Data owns the port only in an
  // undisturbed IDLE cycle; PROBE is the only state that searches with EntryHi.
  always_comb begin
    dt_gnt_s    = 1'b0;
    tp_done_s   = 1'b0;
    probe_cap_s = 1'b0;
    sync_busy_s = 1'b0;
    s1_vpn2_s   = dt_vpn2;
    s1_odd_s    = dt_odd;
    case (state_r)
      TPS_IDLE: begin
        dt_gnt_s = dt_req && !tlbw_commit && !flush && !tp_req;
      end
      TPS_HAZ: begin
        dt_gnt_s = 1'b0;
      end
      TPS_PROBE: begin
        s1_vpn2_s   = eh_vpn2(cp0_entryhi);
        s1_odd_s    = cp0_entryhi[EH_ODD_BIT];
        probe_cap_s = !flush && !tlbw_commit;
      end
      TPS_RESP: begin
        tp_done_s = !flush && !tlbw_commit;
      end
      TPS_SYNC: begin
        sync_busy_s = 1'b1;
      end
      default: begin
        dt_gnt_s = 1'b0;
      end
    endcase
  end

  // Probe result: captured only from a probe that is not being flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      tp_found_r <= 1'b0;
      tp_index_r <= {IDXW{1'b0}};
    end else if (probe_cap_s) begin
      tp_found_r <= s1_found;
      tp_index_r <= s1_index;
    end else begin
      tp_found_r <= tp_found_r;
      tp_index_r <= tp_index_r;
    end
  end

  assign deny_en_s = dt_req && !dt_gnt_s;

  sat_counter #(
    .W(CNTW)
  ) u_deny_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (deny_en_s),
    .cnt  (deny_cnt)
  );

  assign dt_gnt      = dt_gnt_s;
  assign tp_done     = tp_done_s;
  assign sync_busy   = sync_busy_s;
  assign tp_found    = tp_found_r;
  assign tp_index    = tp_index_r;
  assign s1_vpn2     = s1_vpn2_s;
  assign s1_odd_page = s1_odd_s;
  assign s1_asid     = eh_asid(cp0_entryhi);

endmodule

// File: tb/tb_tlb_port_sched.sv
// tb_tlb_port_sched: directed self-checking bench for tlb_port_sched,
// built with a 4-bit deny counter so saturation is reachable.
module tb_tlb_port_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        dt_req;
  logic [18:0] dt_vpn2;
  logic        dt_odd;
  logic        dt_gnt;
  logic        tp_req;
  logic        tp_done;
  logic        tp_found;
  logic [3:0]  tp_index;
  logic        eh_wr_pending;
  logic [31:0] cp0_entryhi;
  logic [18:0] s1_vpn2;
  logic        s1_odd_page;
  logic [7:0]  s1_asid;
  logic        s1_found;
  logic [3:0]  s1_index;
  logic        tlbw_commit;
  logic        flush;
  logic        fetch_restart;
  logic        sync_busy;
  logic [3:0]  deny_cnt;

  // simple one-entry TLB stand-in
  logic        tlb_hit_en;
  logic [18:0] tlb_vpn2;
  logic [7:0]  tlb_asid;
  logic [3:0]  tlb_idx;

  int checks = 0;
  int errors = 0;
  int exp_deny = 0;

  tlb_port_sched #(
    .TLBNUM(16),
    .IDXW  (4),
    .CNTW  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dt_req       (dt_req),
    .dt_vpn2      (dt_vpn2),
    .dt_odd       (dt_odd),
    .dt_gnt       (dt_gnt),
    .tp_req       (tp_req),
    .tp_done      (tp_done),
    .tp_found     (tp_found),
    .tp_index     (tp_index),
    .eh_wr_pending(eh_wr_pending),
    .cp0_entryhi  (cp0_entryhi),
    .s1_vpn2      (s1_vpn2),
    .s1_odd_page  (s1_odd_page),
    .s1_asid      (s1_asid),
    .s1_found     (s1_found),
    .s1_index     (s1_index),
    .tlbw_commit  (tlbw_commit),
    .flush        (flush),
    .fetch_restart(fetch_restart),
    .sync_busy    (sync_busy),
    .deny_cnt     (deny_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    s1_found = tlb_hit_en && (s1_vpn2 == tlb_vpn2) && (s1_asid == tlb_asid);
    s1_index = tlb_idx;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_deny(input int n);
    exp_deny = exp_deny + n;
    if (exp_deny > 15) exp_deny = 15;
  endtask

  // advance to just after the next active edge
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; dt_req = 1'b0; dt_vpn2 = 19'h00123; dt_odd = 1'b1;
    tp_req = 1'b0; eh_wr_pending = 1'b0; cp0_entryhi = 32'h0000_0005;
    tlbw_commit = 1'b0; flush = 1'b0; fetch_restart = 1'b0;
    tlb_hit_en = 1'b0; tlb_vpn2 = 19'h00012; tlb_asid = 8'h05; tlb_idx = 4'd7;

    // reset state
    next_cyc();
    @(negedge clk);
    check_val("rst_found", {31'd0, tp_found}, 32'd0);
    check_val("rst_index", {28'd0, tp_index}, 32'd0);
    check_val("rst_done", {31'd0, tp_done}, 32'd0);
    check_val("rst_deny", {28'd0, deny_cnt}, 32'd0);
    check_val("rst_gnt", {31'd0, dt_gnt}, 32'd0);
    check_val("rst_sync", {31'd0, sync_busy}, 32'd0);
    next_cyc();
    reset = 1'b0;

    // data only
    dt_req = 1'b1;
    @(negedge clk);
    check_val("data_gnt", {31'd0, dt_gnt}, 32'd1);
    check_val("data_vpn2", {13'd0, s1_vpn2}, 32'h00123);
    check_val("data_odd", {31'd0, s1_odd_page}, 32'd1);
    check_val("data_asid", {24'd0, s1_asid}, 32'h05);
    next_cyc();
    dt_req = 1'b0;
    @(negedge clk);
    check_val("data_deny", {28'd0, deny_cnt}, 32'd0);

    // probe hit
    next_cyc();
    cp0_entryhi = 32'h0002_4005; tlb_hit_en = 1'b1; tp_req = 1'b1;
    @(negedge clk);
    check_val("probe_c0_done", {31'd0, tp_done}, 32'd0);
    next_cyc();
    tp_req = 1'b0;
    @(negedge clk);
    check_val("probe_vpn2", {13'd0, s1_vpn2}, 32'h00012);
    check_val("probe_odd", {31'd0, s1_odd_page}, 32'd0);
    check_val("probe_c1_done", {31'd0, tp_done}, 32'd0);
    next_cyc();
    @(negedge clk);
    check_val("probe_done", {31'd0, tp_done}, 32'd1);
    check_val("probe_found", {31'd0, tp_found}, 32'd1);
    check_val("probe_index", {28'd0, tp_index}, 32'd7);
    next_cyc();
    @(negedge clk);
    check_val("probe_done_pulse", {31'd0, tp_done}, 32'd0);
    check_val("probe_found_hold", {31'd0, tp_found}, 32'd1);

    // hazard: eh_wr_pending high for cycles 0-2, probe in 4, done in 5
    for (int i = 0; i <= 6; i++) begin
      next_cyc();
      tp_req = (i <= 3);
      eh_wr_pending = (i <= 2);
      dt_req = 1'b1;
      @(negedge clk);
      check_val($sformatf("haz_gnt_%0d", i), {31'd0, dt_gnt}, (i == 6) ? 32'd1 : 32'd0);
      check_val($sformatf("haz_done_%0d", i), {31'd0, tp_done}, (i == 5) ? 32'd1 : 32'd0);
      if (i == 4) check_val("haz_probe_vpn2", {13'd0, s1_vpn2}, 32'h00012);
    end
    add_deny(6);
    next_cyc();
    dt_req = 1'b0; tp_req = 1'b0; eh_wr_pending = 1'b0;
    @(negedge clk);
    check_val("haz_deny", {28'd0, deny_cnt}, exp_deny);

    // flush in PROBE
    tlb_idx = 4'd9;
    next_cyc();
    tp_req = 1'b1;
    next_cyc();
    tp_req = 1'b0; flush = 1'b1; dt_req = 1'b1;
    @(negedge clk);
    check_val("flush_probe_gnt", {31'd0, dt_gnt}, 32'd0);
    check_val("flush_probe_done", {31'd0, tp_done}, 32'd0);
    add_deny(1);
    next_cyc();
    flush = 1'b0;
    @(negedge clk);
    check_val("flush_next_gnt", {31'd0, dt_gnt}, 32'd1);
    check_val("flush_next_done", {31'd0, tp_done}, 32'd0);
    check_val("flush_found_hold", {31'd0, tp_found}, 32'd1);
    check_val("flush_index_hold", {28'd0, tp_index}, 32'd7);
    check_val("flush_deny", {28'd0, deny_cnt}, exp_deny);

    // TLBWI sync
    next_cyc();
    dt_req = 1'b0; tlbw_commit = 1'b1;
    @(negedge clk);
    check_val("sync_c0_busy", {31'd0, sync_busy}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      next_cyc();
      tlbw_commit = 1'b0; dt_req = 1'b1; fetch_restart = (i == 5);
      @(negedge clk);
      check_val($sformatf("sync_busy_%0d", i), {31'd0, sync_busy}, 32'd1);
      check_val($sformatf("sync_gnt_%0d", i), {31'd0, dt_gnt}, 32'd0);
    end
    add_deny(5);
    next_cyc();
    fetch_restart = 1'b0;
    @(negedge clk);
    check_val("sync_exit_busy", {31'd0, sync_busy}, 32'd0);
    check_val("sync_exit_gnt", {31'd0, dt_gnt}, 32'd1);
    check_val("sync_deny", {28'd0, deny_cnt}, exp_deny);

    // commit together with flush enters SYNC; restart beats a new commit
    next_cyc();
    dt_req = 1'b0; tlbw_commit = 1'b1; flush = 1'b1;
    next_cyc();
    tlbw_commit = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_val("commit_flush_sync", {31'd0, sync_busy}, 32'd1);
    next_cyc();
    tlbw_commit = 1'b1; fetch_restart = 1'b1;
    next_cyc();
    tlbw_commit = 1'b0; fetch_restart = 1'b0;
    @(negedge clk);
    check_val("restart_wins", {31'd0, sync_busy}, 32'd0);

    // saturation: 20 denied cycles in SYNC
    next_cyc();
    tlbw_commit = 1'b1;
    next_cyc();
    tlbw_commit = 1'b0; dt_req = 1'b1;
    repeat (20) next_cyc();
    add_deny(20);
    dt_req = 1'b0;
    @(negedge clk);
    check_val("sat_deny", {28'd0, deny_cnt}, exp_deny);
    check_val("sat_value", {28'd0, deny_cnt}, 32'hF);
    next_cyc();
    fetch_restart = 1'b1;
    next_cyc();
    fetch_restart = 1'b0; tp_req = 1'b1; tlb_idx = 4'd3;
    next_cyc();
    tp_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_val("rstp_vpn2", {13'd0, s1_vpn2}, 32'h00012);
    next_cyc();
    reset = 1'b0; dt_req = 1'b1;
    exp_deny = 0;
    @(negedge clk);
    check_val("rstp_done", {31'd0, tp_done}, 32'd0);
    check_val("rstp_found", {31'd0, tp_found}, 32'd0);
    check_val("rstp_index", {28'd0, tp_index}, 32'd0);
    check_val("rstp_deny", {28'd0, deny_cnt}, exp_deny);
    check_val("rstp_sync", {31'd0, sync_busy}, 32'd0);
    check_val("rstp_gnt", {31'd0, dt_gnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
